// File: rtl/peridot_epcs_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : peridot_epcs_read_sequencer
// Purpose  : Shares the boot SPI-flash byte engine between host CSR writes
//            and a hardware streaming read port.
// Revision : 1.0 - initial release
// ============================================================================
module peridot_epcs_read_sequencer #(
  parameter logic [7:0] READ_CMD    = 8'h03,
  parameter int         DUMMY_BYTES = 0,
  parameter int         ADDR_WIDTH  = 24
) (
  input  logic                  csi_clk,
  input  logic                  rsi_reset,
  input  logic                  host_write,
  input  logic [31:0]           host_writedata,
  output logic [31:0]           host_readdata,
  input  logic                  req_start,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [15:0]           req_length,
  output logic                  req_busy,
  output logic [7:0]            req_data,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  spi_write,
  output logic [31:0]           spi_writedata,
  input  logic [31:0]           spi_readdata
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_HOST = 3'd1,
    S_ISSUE     = 3'd2,
    S_GAP       = 3'd3,
    S_POLL      = 3'd4,
    S_DELIVER   = 3'd5,
    S_RELEASE   = 3'd6
  } state_t;

  // Index of the first data byte; header is opcode, three address bytes, dummies.
  localparam logic [4:0] c_hdr_len = 5'(4 + DUMMY_BYTES);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_count;
  logic [4:0]            r_idx;
  logic                  r_select;
  logic                  r_busy;
  logic                  r_valid;
  logic [7:0]            r_data;
  logic                  r_spi_write;
  logic [31:0]           r_spi_writedata;
  logic                  w_host_owns;

  function automatic logic [31:0] f_word(input logic [4:0] idx,
                                         input logic [ADDR_WIDTH-1:0] addr);
    logic [7:0] tx;
    case (idx)
      5'd0:    tx = READ_CMD;
      5'd1:    tx = addr[23:16];
      5'd2:    tx = addr[15:8];
      5'd3:    tx = addr[7:0];
      default: tx = 8'h00;
    endcase
    return {22'b0, 1'b1, 1'b1, tx};
  endfunction

  assign w_host_owns   = (r_state == S_IDLE) || (r_state == S_WAIT_HOST);
  assign spi_write     = w_host_owns ? host_write     : r_spi_write;
  assign spi_writedata = w_host_owns ? host_writedata : r_spi_writedata;
  // While the sequencer drives the engine the host sees "not ready" and stalls.
  assign host_readdata = w_host_owns ? spi_readdata   : {22'b0, 1'b0, r_select, 8'h00};

  assign req_busy  = r_busy;
  assign req_valid = r_valid;
  assign req_data  = r_data;

  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_count         <= 16'd0;
      r_idx           <= 5'd0;
      r_select        <= 1'b0;
      r_busy          <= 1'b0;
      r_valid         <= 1'b0;
      r_data          <= 8'h00;
      r_spi_write     <= 1'b0;
      r_spi_writedata <= 32'h0;
    end else begin
      if (w_host_owns && host_write) begin
        r_select <= host_writedata[8];
      end
      case (r_state)
        S_IDLE: begin
          if (req_start && (req_length != 16'd0)) begin
            r_addr  <= req_address;
            r_count <= req_length;
            r_busy  <= 1'b1;
            r_state <= S_WAIT_HOST;
          end
        end
        S_WAIT_HOST: begin
          // The host may still hold chip select; wait until it lets go.
          if (!r_select && !host_write) begin
            r_idx           <= 5'd0;
            r_spi_write     <= 1'b1;
            r_spi_writedata <= f_word(5'd0, r_addr);
            r_state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_spi_write <= 1'b0;
          r_state     <= S_GAP;
        end
        S_GAP: begin
          r_state <= S_POLL;
        end
        S_POLL: begin
          if (spi_readdata[9]) begin
            if (r_idx < c_hdr_len) begin
              r_idx           <= r_idx + 5'd1;
              r_spi_write     <= 1'b1;
              r_spi_writedata <= f_word(r_idx + 5'd1, r_addr);
              r_state         <= S_ISSUE;
            end else begin
              r_data  <= spi_readdata[7:0];
              r_valid <= 1'b1;
              r_state <= S_DELIVER;
            end
          end
        end
        S_DELIVER: begin
          if (req_ready) begin
            r_valid <= 1'b0;
            r_count <= r_count - 16'd1;
            r_spi_write <= 1'b1;
            if (r_count == 16'd1) begin
              r_spi_writedata <= 32'h0;
              r_state         <= S_RELEASE;
            end else begin
              r_spi_writedata <= f_word(r_idx, r_addr);
              r_state         <= S_ISSUE;
            end
          end
        end
        S_RELEASE: begin
          r_spi_write <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_spi_write <= 1'b0;
          r_busy      <= 1'b0;
          r_valid     <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_peridot_epcs_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_peridot_epcs_read_sequencer
// Purpose  : Self-checking bench with a behavioural SPI byte-engine model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_peridot_epcs_read_sequencer;

  localparam logic [7:0] TB_CMD   = 8'h03;
  localparam int         TB_DUMMY = 0;
  localparam int         HDR      = 4 + TB_DUMMY;

  logic        csi_clk = 1'b0;
  logic        rsi_reset = 1'b1;
  logic        host_write = 1'b0;
  logic [31:0] host_writedata = 32'h0;
  logic [31:0] host_readdata;
  logic        req_start = 1'b0;
  logic [23:0] req_address = 24'h0;
  logic [15:0] req_length = 16'h0;
  logic        req_busy;
  logic [7:0]  req_data;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic        spi_write;
  logic [31:0] spi_writedata;
  logic [31:0] spi_readdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] wlog[$];
  logic [31:0] exp_q[$];
  logic [7:0]  rx_log[$];
  logic [7:0]  got[$];

  int          core_lat = 0;
  int          core_cnt;
  logic        core_ready;
  logic        core_sel;
  logic [7:0]  core_rx;

  peridot_epcs_read_sequencer #(
    .READ_CMD    (TB_CMD),
    .DUMMY_BYTES (TB_DUMMY),
    .ADDR_WIDTH  (24)
  ) dut (
    .csi_clk        (csi_clk),
    .rsi_reset      (rsi_reset),
    .host_write     (host_write),
    .host_writedata (host_writedata),
    .host_readdata  (host_readdata),
    .req_start      (req_start),
    .req_address    (req_address),
    .req_length     (req_length),
    .req_busy       (req_busy),
    .req_data       (req_data),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .spi_write      (spi_write),
    .spi_writedata  (spi_writedata),
    .spi_readdata   (spi_readdata)
  );

  initial forever #5 csi_clk = ~csi_clk;

  // SPI byte engine: a start write drops ready for core_lat cycles, then returns a random byte.
  assign spi_readdata = {22'b0, core_ready, core_sel, core_rx};
  always @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      core_ready <= 1'b1;
      core_sel   <= 1'b0;
      core_rx    <= 8'h00;
      core_cnt   <= 0;
    end else if (spi_write) begin
      core_sel <= spi_writedata[8];
      if (spi_writedata[9]) begin
        core_ready <= 1'b0;
        core_cnt   <= (core_lat == 0) ? int'($urandom_range(1, 8)) : core_lat;
      end
    end else if (!core_ready) begin
      if (core_cnt <= 1) begin
        rx_log.push_back(8'($urandom));
        core_rx    <= rx_log[$];
        core_ready <= 1'b1;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  always @(posedge csi_clk) begin
    if (!rsi_reset && spi_write) wlog.push_back(spi_writedata);
    if (!rsi_reset && req_valid && req_ready) got.push_back(req_data);
  end

  function automatic void build_expected(input logic [23:0] a, input int n);
    exp_q.delete();
    if (n == 0) return;
    exp_q.push_back({22'b0, 2'b11, TB_CMD});
    exp_q.push_back({22'b0, 2'b11, a[23:16]});
    exp_q.push_back({22'b0, 2'b11, a[15:8]});
    exp_q.push_back({22'b0, 2'b11, a[7:0]});
    for (int i = 0; i < TB_DUMMY + n; i++) exp_q.push_back(32'h0000_0300);
    exp_q.push_back(32'h0000_0000);
  endfunction

  task automatic clear_logs();
    wlog.delete();
    rx_log.delete();
    got.delete();
  endtask

  task automatic wait_idle(input int pct);
    bit done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      if (req_busy !== 1'b1) done = 1'b1;
      else begin
        req_ready = ($urandom_range(0, 99) < pct);
        @(negedge csi_clk);
      end
    end
    req_ready = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL idle_timeout: req_busy=%b after 3000 cycles, required 0", req_busy);
    end
  endtask

  task automatic do_txn(input logic [23:0] a, input int n, input int pct);
    clear_logs();
    build_expected(a, n);
    req_address = a;
    req_length  = 16'(n);
    req_start   = 1'b1;
    @(negedge csi_clk);
    req_start = 1'b0;
    wait_idle(pct);
  endtask

  task automatic test_reset();
    rsi_reset = 1'b1;
    repeat (3) @(negedge csi_clk);
    total++; if (req_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", req_busy); end
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b required 0", req_valid); end
    total++; if (req_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h required 00", req_data); end
    total++; if (spi_write !== 1'b0) begin bad++; $display("FAIL rst_spi_write: got %b required 0", spi_write); end
    total++; if (spi_writedata !== 32'h0) begin bad++; $display("FAIL rst_spi_wdata: got %h required 0", spi_writedata); end
    total++; if (host_readdata !== 32'h200) begin bad++; $display("FAIL rst_host_rdata: got %h required 00000200", host_readdata); end
    rsi_reset = 1'b0;
    @(negedge csi_clk);
  endtask

  task automatic test_basic_read();
    core_lat = 8;
    do_txn(24'h0A1B2C, 2, 100);
    total++;
    if (wlog.size() != exp_q.size()) begin
      bad++; $display("FAIL basic_word_count: got %0d required %0d", wlog.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (wlog[i] !== exp_q[i]) begin bad++; $display("FAIL basic_word[%0d]: got %h required %h", i, wlog[i], exp_q[i]); end
    end
    total++;
    if (got.size() != 2) begin
      bad++; $display("FAIL basic_data_count: got %0d required 2", got.size());
    end else for (int i = 0; i < 2; i++) begin
      total++;
      if (got[i] !== rx_log[HDR+i]) begin bad++; $display("FAIL basic_data[%0d]: got %h required %h", i, got[i], rx_log[HDR+i]); end
    end
    total++; if (req_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b required 0", req_busy); end
  endtask

  task automatic test_wait_host();
    core_lat = 2;
    host_write = 1'b1; host_writedata = 32'h100;
    @(negedge csi_clk);
    host_write = 1'b0;
    clear_logs();
    req_address = 24'h123456; req_length = 16'd1; req_start = 1'b1;
    @(negedge csi_clk);
    req_start = 1'b0;
    repeat (10) @(negedge csi_clk);
    total++; if (wlog.size() != 0) begin bad++; $display("FAIL wh_no_write: got %0d writes required 0", wlog.size()); end
    total++; if (req_busy !== 1'b1) begin bad++; $display("FAIL wh_busy: got %b required 1", req_busy); end
    total++; if (host_readdata !== spi_readdata) begin bad++; $display("FAIL wh_host_rdata: got %h required %h", host_readdata, spi_readdata); end
    host_write = 1'b1; host_writedata = 32'h000;
    #1;
    total++; if (spi_write !== 1'b1 || spi_writedata !== 32'h0) begin bad++; $display("FAIL wh_pass: got %b/%h required 1/0", spi_write, spi_writedata); end
    @(negedge csi_clk);
    host_write = 1'b0;
    #1;
    total++; if (spi_write !== 1'b0) begin bad++; $display("FAIL wh_hold: got %b required 0", spi_write); end
    @(negedge csi_clk);
    total++; if (spi_write !== 1'b1 || spi_writedata !== 32'h303) begin bad++; $display("FAIL wh_first_issue: got %b/%h required 1/00000303", spi_write, spi_writedata); end
    wait_idle(100);
    total++; if (got.size() != 1 || got[0] !== rx_log[HDR]) begin bad++; $display("FAIL wh_data: got %0d bytes first %h required 1 byte %h", got.size(), got[0], rx_log[HDR]); end
  endtask

  task automatic test_host_blocked();
    core_lat = 3;
    clear_logs();
    build_expected(24'hC0FFEE, 3);
    req_address = 24'hC0FFEE; req_length = 16'd3; req_start = 1'b1;
    @(negedge csi_clk);
    req_start = 1'b0;
    repeat (4) @(negedge csi_clk);
    host_write = 1'b1; host_writedata = 32'h2A5;
    #1;
    total++; if (spi_write === 1'b1 && spi_writedata[7:0] === 8'hA5) begin bad++; $display("FAIL hb_leak: got %h on core required no host byte", spi_writedata); end
    total++; if (host_readdata !== 32'h0) begin bad++; $display("FAIL hb_rdata: got %h required 0", host_readdata); end
    @(negedge csi_clk);
    host_writedata = 32'h1A5;
    @(negedge csi_clk);
    host_write = 1'b0;
    #1;
    total++; if (host_readdata !== 32'h0) begin bad++; $display("FAIL hb_tracker: got %h required 0", host_readdata); end
    wait_idle(70);
    total++;
    if (wlog.size() != exp_q.size()) begin
      bad++; $display("FAIL hb_word_count: got %0d required %0d", wlog.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (wlog[i] !== exp_q[i]) begin bad++; $display("FAIL hb_word[%0d]: got %h required %h", i, wlog[i], exp_q[i]); end
    end
    total++; if (host_readdata !== spi_readdata) begin bad++; $display("FAIL hb_idle_rdata: got %h required %h", host_readdata, spi_readdata); end
  endtask

  task automatic test_backpressure();
    logic [7:0] d0;
    int         n0;
    core_lat = 2;
    clear_logs();
    build_expected(24'h5A5A01, 2);
    req_ready = 1'b0;
    req_address = 24'h5A5A01; req_length = 16'd2; req_start = 1'b1;
    @(negedge csi_clk);
    req_start = 1'b0;
    for (int c = 0; c < 300 && req_valid !== 1'b1; c++) @(negedge csi_clk);
    total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL bp_first_valid: got %b required 1", req_valid); end
    d0 = req_data;
    n0 = wlog.size();
    for (int c = 0; c < 20; c++) begin
      @(negedge csi_clk);
      total++;
      if (req_valid !== 1'b1 || req_data !== d0 || spi_write !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d]: got v=%b d=%h w=%b required 1/%h/0", c, req_valid, req_data, spi_write, d0);
      end
    end
    total++; if (wlog.size() != n0) begin bad++; $display("FAIL bp_no_issue: got %0d writes required %0d", wlog.size(), n0); end
    wait_idle(100);
    total++;
    if (got.size() != 2) begin
      bad++; $display("FAIL bp_data_count: got %0d required 2", got.size());
    end else for (int i = 0; i < 2; i++) begin
      total++;
      if (got[i] !== rx_log[HDR+i]) begin bad++; $display("FAIL bp_data[%0d]: got %h required %h", i, got[i], rx_log[HDR+i]); end
    end
    total++; if (got.size() > 0 && got[0] !== d0) begin bad++; $display("FAIL bp_first_byte: got %h required %h", got[0], d0); end
  endtask

  task automatic test_zero_and_busy();
    core_lat = 0;
    clear_logs();
    req_address = 24'h000100; req_length = 16'd0; req_start = 1'b1;
    @(negedge csi_clk);
    req_start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      total++; if (req_busy !== 1'b0) begin bad++; $display("FAIL zero_busy[%0d]: got %b required 0", c, req_busy); end
      @(negedge csi_clk);
    end
    total++; if (wlog.size() != 0) begin bad++; $display("FAIL zero_writes: got %0d required 0", wlog.size()); end
    clear_logs();
    build_expected(24'h3C3C3C, 2);
    req_address = 24'h3C3C3C; req_length = 16'd2; req_start = 1'b1;
    @(negedge csi_clk);
    req_start = 1'b0;
    repeat (3) @(negedge csi_clk);
    req_address = 24'hFFFFFF; req_length = 16'd5; req_start = 1'b1;
    @(negedge csi_clk);
    req_start = 1'b0;
    wait_idle(80);
    total++; if (got.size() != 2) begin bad++; $display("FAIL busy_ignore_count: got %0d required 2", got.size()); end
    total++;
    if (wlog.size() != exp_q.size()) begin
      bad++; $display("FAIL busy_word_count: got %0d required %0d", wlog.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (wlog[i] !== exp_q[i]) begin bad++; $display("FAIL busy_word[%0d]: got %h required %h", i, wlog[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] a;
    core_lat = 6;
    clear_logs();
    req_address = 24'h777777; req_length = 16'd4; req_start = 1'b1;
    @(negedge csi_clk);
    req_start = 1'b0;
    for (int c = 0; c < 200 && wlog.size() < 4; c++) @(negedge csi_clk);
    total++; if (wlog.size() < 4) begin bad++; $display("FAIL rm_reach: got %0d writes required 4", wlog.size()); end
    repeat (2) @(negedge csi_clk);
    #2 rsi_reset = 1'b1;
    #1;
    total++; if (req_busy !== 1'b0) begin bad++; $display("FAIL rm_busy: got %b required 0", req_busy); end
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL rm_valid: got %b required 0", req_valid); end
    total++; if (spi_write !== 1'b0) begin bad++; $display("FAIL rm_spi_write: got %b required 0", spi_write); end
    @(negedge csi_clk);
    rsi_reset = 1'b0;
    @(negedge csi_clk);
    core_lat = 0;
    a = 24'($urandom);
    do_txn(a, 3, 60);
    total++;
    if (wlog.size() != exp_q.size()) begin
      bad++; $display("FAIL rm_word_count: got %0d required %0d", wlog.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (wlog[i] !== exp_q[i]) begin bad++; $display("FAIL rm_word[%0d]: got %h required %h", i, wlog[i], exp_q[i]); end
    end
    total++;
    if (got.size() != 3) begin
      bad++; $display("FAIL rm_data_count: got %0d required 3", got.size());
    end else for (int i = 0; i < 3; i++) begin
      total++;
      if (got[i] !== rx_log[HDR+i]) begin bad++; $display("FAIL rm_data[%0d]: got %h required %h", i, got[i], rx_log[HDR+i]); end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      logic [23:0] a;
      int          n;
      a = 24'($urandom);
      n = int'($urandom_range(1, 5));
      core_lat = 0;
      do_txn(a, n, int'($urandom_range(30, 100)));
      total++;
      if (wlog.size() != exp_q.size()) begin
        bad++; $display("FAIL rnd%0d_word_count: got %0d required %0d", t, wlog.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        total++;
        if (wlog[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_word[%0d]: got %h required %h", t, i, wlog[i], exp_q[i]); end
      end
      total++;
      if (got.size() != n) begin
        bad++; $display("FAIL rnd%0d_data_count: got %0d required %0d", t, got.size(), n);
      end else for (int i = 0; i < n; i++) begin
        total++;
        if (got[i] !== rx_log[HDR+i]) begin bad++; $display("FAIL rnd%0d_data[%0d]: got %h required %h", t, i, got[i], rx_log[HDR+i]); end
      end
      repeat (2) @(negedge csi_clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_wait_host();
    test_host_blocked();
    test_backpressure();
    test_zero_and_busy();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
